// File: rtl/fm_modfreq_meas.sv
//============================================================================
// Module      : fm_modfreq_meas
// Description : Modulation-frequency and peak-to-peak meter for the output of
//               the FM demodulator. A Schmitt zero-crossing detector times
//               NUM_PERIODS modulation cycles, a 32-step restoring divider
//               turns the period count into Hz, and the max/min over the same
//               window gives the demodulated peak-to-peak amplitude.
//               Optional macro FREQ_AVG_EN: report the mean of the last four
//               valid frequency results instead of the single result.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module fm_modfreq_meas #(
  parameter int unsigned CLK_FREQ    = 32000000,
  parameter int unsigned NUM_PERIODS = 8,
  parameter int unsigned MIDSCALE    = 512,
  parameter int unsigned HYST        = 16,
  parameter int unsigned TIMEOUT     = 16000000,
  parameter int unsigned MIN_VPP     = 20
) (
  input  logic        clk_32m,
  input  logic        rst,
  input  logic        en,
  input  logic [9:0]  demod_in,
  output logic [12:0] mod_freq,
  output logic [9:0]  vpp,
  output logic        meas_valid,
  output logic        no_signal,
  output logic        busy
);

  // Schmitt thresholds are signed so that HYST > MIDSCALE still behaves
  localparam logic signed [31:0] c_HI_TH     = 32'(MIDSCALE + HYST);
  localparam logic signed [31:0] c_LO_TH     = 32'(MIDSCALE) - 32'(HYST);
  localparam logic [31:0]        c_NUM_CLK   = 32'(NUM_PERIODS) * 32'(CLK_FREQ);
  localparam logic [31:0]        c_TO_LAST   = 32'(TIMEOUT - 1);
  localparam logic [31:0]        c_MIN_VPP   = 32'(MIN_VPP);
  localparam logic [7:0]         c_LAST_EDGE = 8'(NUM_PERIODS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_DIVIDE  = 2'd2,
    S_UPDATE  = 2'd3
  } state_t;

  state_t      state_q, state_d;

  // input conditioning
  logic        hi_q, w_hi_d;
  logic        rise_q;
  logic [9:0]  smp_q;
  logic        smp_vld_q;
  logic signed [31:0] w_smp;

  // measurement window
  logic [31:0] per_q, per_d;
  logic [31:0] to_q, to_d;
  logic [7:0]  edge_q, edge_d;
  logic [9:0]  max_q, max_d;
  logic [9:0]  min_q, min_d;

  // divider
  logic [31:0] dvsr_q, dvsr_d;
  logic [31:0] dvd_q, dvd_d;     // dividend on entry, quotient on exit
  logic [31:0] rem_q, rem_d;
  logic [4:0]  step_q, step_d;
  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [32:0] w_rem_sub;

  // results
  logic [12:0] mod_freq_q, mod_freq_d;
  logic [9:0]  vpp_q, vpp_d;
  logic        valid_q, valid_d;
  logic        nosig_q, nosig_d;

  logic [9:0]  w_vpp;
  logic        w_low_amp;
  logic [12:0] w_quot_sat;
  logic        w_to_fire;

`ifdef FREQ_AVG_EN
  // The newest quotient plus three held ones form the 4-deep averaging window
  logic [12:0] hist_q [3];
  logic [12:0] hist_d [3];
  logic [2:0]  hcnt_q, hcnt_d;
  logic [2:0]  w_cnt_new;
  logic [14:0] w_sum;
  logic [18:0] w_prod3;
  logic [12:0] w_mean;
`endif

  assign w_smp = $signed({22'd0, demod_in});

  // Schmitt comparator: only a qualified sample can move the hi state
  always_comb begin
    w_hi_d = hi_q;
    if (en) begin
      if (w_smp >= c_HI_TH) begin
        w_hi_d = 1'b1;
      end else if (w_smp <= c_LO_TH) begin
        w_hi_d = 1'b0;
      end
    end
  end

  // Divider datapath: one restoring step per cycle, quotient shifts into dvd_q
  always_comb begin
    w_rem_sh  = {rem_q, dvd_q[31]};
    w_ge      = (w_rem_sh >= {1'b0, dvsr_q});
    w_rem_sub = w_rem_sh - {1'b0, dvsr_q};
  end

  // Result shaping from the finished window
  always_comb begin
    w_vpp      = max_q - min_q;
    w_low_amp  = ({22'd0, w_vpp} < c_MIN_VPP);
    w_quot_sat = (|dvd_q[31:13]) ? 13'h1FFF : dvd_q[12:0];
  end

`ifdef FREQ_AVG_EN
  // Running mean over however many valid results are held (1..4)
  always_comb begin
    w_cnt_new = (hcnt_q == 3'd4) ? 3'd4 : hcnt_q + 3'd1;
    w_sum     = {2'b00, w_quot_sat} + {2'b00, hist_q[0]}
              + {2'b00, hist_q[1]} + {2'b00, hist_q[2]};
    w_prod3   = {4'd0, w_sum} * 19'd21;
    case (w_cnt_new)
      3'd1:    w_mean = w_sum[12:0];
      3'd2:    w_mean = w_sum[13:1];
      3'd3:    w_mean = w_prod3[18:6];
      default: w_mean = w_sum[14:2];
    endcase
  end
`endif

  // Next-state and datapath control for the measurement sequence
  always_comb begin
    state_d    = state_q;
    per_d      = (per_q == 32'hFFFF_FFFF) ? per_q : per_q + 32'd1;
    to_d       = (to_q == 32'hFFFF_FFFF) ? to_q : to_q + 32'd1;
    edge_d     = edge_q;
    max_d      = max_q;
    min_d      = min_q;
    dvsr_d     = dvsr_q;
    dvd_d      = dvd_q;
    rem_d      = rem_q;
    step_d     = step_q;
    mod_freq_d = mod_freq_q;
    vpp_d      = vpp_q;
    valid_d    = 1'b0;
    nosig_d    = nosig_q;
    w_to_fire  = 1'b0;
`ifdef FREQ_AVG_EN
    hist_d     = hist_q;
    hcnt_d     = hcnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (rise_q) begin
          per_d   = 32'd1;
          to_d    = 32'd0;
          edge_d  = 8'd0;
          max_d   = smp_q;
          min_d   = smp_q;
          state_d = S_MEASURE;
        end else if (to_q >= c_TO_LAST) begin
          w_to_fire = 1'b1;
        end
      end

      S_MEASURE: begin
        if (smp_vld_q) begin
          if (smp_q > max_q) max_d = smp_q;
          if (smp_q < min_q) min_d = smp_q;
        end
        // A final rise beats a timeout landing on the same cycle
        if (rise_q) begin
          edge_d = edge_q + 8'd1;
          if (edge_q == c_LAST_EDGE) begin
            dvsr_d  = per_q;
            dvd_d   = c_NUM_CLK + (per_q >> 1);
            rem_d   = 32'd0;
            step_d  = 5'd0;
            state_d = S_DIVIDE;
          end
        end else if (to_q >= c_TO_LAST) begin
          w_to_fire = 1'b1;
        end
      end

      S_DIVIDE: begin
        rem_d  = w_ge ? w_rem_sub[31:0] : w_rem_sh[31:0];
        dvd_d  = {dvd_q[30:0], w_ge};
        step_d = step_q + 5'd1;
        if (step_q == 5'd31) begin
          state_d = S_UPDATE;
        end
      end

      S_UPDATE: begin
        vpp_d   = w_vpp;
        valid_d = 1'b1;
        state_d = S_IDLE;
        if (w_low_amp) begin
          mod_freq_d = 13'd0;
          nosig_d    = 1'b1;
`ifdef FREQ_AVG_EN
          hcnt_d     = 3'd0;
          for (int i = 0; i < 3; i++) hist_d[i] = 13'd0;
`endif
        end else begin
          nosig_d    = 1'b0;
`ifdef FREQ_AVG_EN
          hist_d[0]  = w_quot_sat;
          hist_d[1]  = hist_q[0];
          hist_d[2]  = hist_q[1];
          hcnt_d     = w_cnt_new;
          mod_freq_d = w_mean;
`else
          mod_freq_d = w_quot_sat;
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase

    // No completed window in time: report no signal and start over
    if (w_to_fire) begin
      mod_freq_d = 13'd0;
      vpp_d      = 10'd0;
      nosig_d    = 1'b1;
      valid_d    = 1'b1;
      to_d       = 32'd0;
      state_d    = S_IDLE;
`ifdef FREQ_AVG_EN
      hcnt_d     = 3'd0;
      for (int i = 0; i < 3; i++) hist_d[i] = 13'd0;
`endif
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_32m) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hi_q       <= 1'b0;
      rise_q     <= 1'b0;
      smp_q      <= 10'd0;
      smp_vld_q  <= 1'b0;
      per_q      <= 32'd0;
      to_q       <= 32'd0;
      edge_q     <= 8'd0;
      max_q      <= 10'd0;
      min_q      <= 10'd0;
      dvsr_q     <= 32'd0;
      dvd_q      <= 32'd0;
      rem_q      <= 32'd0;
      step_q     <= 5'd0;
      mod_freq_q <= 13'd0;
      vpp_q      <= 10'd0;
      valid_q    <= 1'b0;
      nosig_q    <= 1'b1;
`ifdef FREQ_AVG_EN
      hcnt_q     <= 3'd0;
      for (int i = 0; i < 3; i++) hist_q[i] <= 13'd0;
`endif
    end else begin
      state_q    <= state_d;
      hi_q       <= w_hi_d;
      rise_q     <= w_hi_d & ~hi_q;
      smp_q      <= en ? demod_in : smp_q;
      smp_vld_q  <= en;
      per_q      <= per_d;
      to_q       <= to_d;
      edge_q     <= edge_d;
      max_q      <= max_d;
      min_q      <= min_d;
      dvsr_q     <= dvsr_d;
      dvd_q      <= dvd_d;
      rem_q      <= rem_d;
      step_q     <= step_d;
      mod_freq_q <= mod_freq_d;
      vpp_q      <= vpp_d;
      valid_q    <= valid_d;
      nosig_q    <= nosig_d;
`ifdef FREQ_AVG_EN
      hcnt_q     <= hcnt_d;
      for (int i = 0; i < 3; i++) hist_q[i] <= hist_d[i];
`endif
    end
  end

  assign mod_freq   = mod_freq_q;
  assign vpp        = vpp_q;
  assign meas_valid = valid_q;
  assign no_signal  = nosig_q;
  assign busy       = (state_q == S_MEASURE) || (state_q == S_DIVIDE);

endmodule

`default_nettype wire

// File: tb/tb_fm_modfreq_meas.sv
//============================================================================
// Module      : tb_fm_modfreq_meas
// Description : Directed self-checking bench for fm_modfreq_meas, scaled to
//               a 64 kHz nominal clock so measurements complete quickly.
//               With CLK_FREQ=64000 and NUM_PERIODS=4 a waveform of period P
//               clocks reads as 64000/P Hz (rounded).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_fm_modfreq_meas;

  localparam int unsigned CLK_FREQ    = 64000;
  localparam int unsigned NUM_PERIODS = 4;
  localparam int unsigned MIDSCALE    = 512;
  localparam int unsigned HYST        = 8;
  localparam int unsigned TIMEOUT     = 3000;
  localparam int unsigned MIN_VPP     = 20;

  logic        clk_32m = 1'b0;
  logic        rst;
  logic        en;
  logic [9:0]  demod_in;
  logic [12:0] mod_freq;
  logic [9:0]  vpp;
  logic        meas_valid;
  logic        no_signal;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  // generator state
  int g_lo, g_hi, g_half, g_phase;
  bit g_sine, g_alt_en;
  int tick_no = 0;
  int sine_tab [32];

  fm_modfreq_meas #(
    .CLK_FREQ    (CLK_FREQ),
    .NUM_PERIODS (NUM_PERIODS),
    .MIDSCALE    (MIDSCALE),
    .HYST        (HYST),
    .TIMEOUT     (TIMEOUT),
    .MIN_VPP     (MIN_VPP)
  ) dut (
    .clk_32m    (clk_32m),
    .rst        (rst),
    .en         (en),
    .demod_in   (demod_in),
    .mod_freq   (mod_freq),
    .vpp        (vpp),
    .meas_valid (meas_valid),
    .no_signal  (no_signal),
    .busy       (busy)
  );

  always #5 clk_32m = ~clk_32m;

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish, expected finish before 60000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_gen(input int lo, input int hi, input int half,
                         input bit sine, input bit alt_en);
    g_lo = lo; g_hi = hi; g_half = half; g_sine = sine; g_alt_en = alt_en;
    g_phase = 0;
  endtask

  // Present one sample, let one clock edge pass, then advance the waveform
  task automatic tick();
    int period;
    if (g_sine) demod_in = 10'(sine_tab[g_phase % 32]);
    else        demod_in = (g_phase < g_half) ? 10'(g_lo) : 10'(g_hi);
    en = g_alt_en ? ((tick_no % 2) == 0) : 1'b1;
    @(posedge clk_32m);
    #1;
    tick_no++;
    period  = g_sine ? 32 : 2 * g_half;
    g_phase = (g_phase + 1) % period;
  endtask

  task automatic wait_valid(input int max_ticks, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!meas_valid && n < max_ticks);
    chk("valid_seen", {31'd0, meas_valid}, 32'd1);
  endtask

  task automatic check_result(input string tag, input int f, input int v, input bit ns);
    chk({tag, "_freq"}, {19'd0, mod_freq}, 32'(f));
    chk({tag, "_vpp"},  {22'd0, vpp}, 32'(v));
    chk({tag, "_nosig"}, {31'd0, no_signal}, {31'd0, ns});
  endtask

  initial begin
    int n;
    int cnt;
    for (int k = 0; k < 32; k++)
      sine_tab[k] = 512 + $rtoi($floor(200.0 * $sin(2.0 * 3.14159265358979 * k / 32.0) + 0.5));

    // reset state
    rst = 1'b1; en = 1'b0; demod_in = 10'd512;
    set_gen(512, 512, 32, 1'b0, 1'b0);
    repeat (3) @(posedge clk_32m);
    #1;
    chk("rst_freq", {19'd0, mod_freq}, 32'd0);
    chk("rst_vpp", {22'd0, vpp}, 32'd0);
    chk("rst_valid", {31'd0, meas_valid}, 32'd0);
    chk("rst_nosig", {31'd0, no_signal}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // constant midscale: timeout exactly TIMEOUT clocks after reset release
    wait_valid(TIMEOUT + 50, n);
    chk("to_latency", 32'(n), 32'(TIMEOUT));
    check_result("to", 0, 0, 1'b1);
    tick();
    chk("to_pulse_len", {31'd0, meas_valid}, 32'd0);

    // 1 kHz square 312/712: first rise at tick 33, result 34 after final rise
    set_gen(312, 712, 32, 1'b0, 1'b0);
    repeat (100) tick();
    chk("busy_measure", {31'd0, busy}, 32'd1);
    wait_valid(400, n);
    chk("sq_latency", 32'(n + 100), 32'd323);
    check_result("sq1k", 1000, 400, 1'b0);

    // 2 kHz sine, amplitude 200
    set_gen(0, 0, 16, 1'b1, 1'b0);
    wait_valid(400, n);
    wait_valid(400, n);
    check_result("sine2k", 2000, 400, 1'b0);

    // en low every other cycle, 1 kHz square
    set_gen(312, 712, 32, 1'b0, 1'b1);
    wait_valid(700, n);
    wait_valid(700, n);
    check_result("alt_en", 1000, 400, 1'b0);

    // small amplitudes around the thresholds (520 / 504)
    set_gen(500, 524, 32, 1'b0, 1'b0);
    wait_valid(700, n);
    wait_valid(700, n);
    check_result("amp24", 1000, 24, 1'b0);

    set_gen(502, 522, 32, 1'b0, 1'b0);
    wait_valid(700, n);
    wait_valid(700, n);
    check_result("amp20", 1000, 20, 1'b0);

    set_gen(503, 521, 32, 1'b0, 1'b0);
    wait_valid(700, n);
    wait_valid(700, n);
    check_result("amp18", 0, 18, 1'b1);

    // inside the hysteresis band: no rise, timeout
    set_gen(506, 518, 32, 1'b0, 1'b0);
    wait_valid(TIMEOUT + 100, n);
    check_result("no_rise", 0, 0, 1'b1);

    // period 6 -> 10667 Hz, saturates
    set_gen(312, 712, 3, 1'b0, 1'b0);
    wait_valid(200, n);
    check_result("sat", 8191, 400, 1'b0);

    // period 8 -> 256016/32 = 8000
    set_gen(312, 712, 4, 1'b0, 1'b0);
    wait_valid(200, n);
    wait_valid(200, n);
    check_result("p8", 8000, 400, 1'b0);

    // period 36 -> 256072/144 = 1778 (rounding lifts 1777.8)
    set_gen(312, 712, 18, 1'b0, 1'b0);
    wait_valid(500, n);
    wait_valid(500, n);
    check_result("p36", 1778, 400, 1'b0);

    // reset in the middle of DIVIDE (divide runs 287..319 ticks after a result)
    set_gen(312, 712, 32, 1'b0, 1'b0);
    wait_valid(700, n);
    wait_valid(700, n);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (meas_valid) cnt++;
    end
    chk("pre_rst_valids", 32'(cnt), 32'd0);
    chk("busy_divide", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_freq", {19'd0, mod_freq}, 32'd0);
    chk("mid_rst_vpp", {22'd0, vpp}, 32'd0);
    chk("mid_rst_valid", {31'd0, meas_valid}, 32'd0);
    chk("mid_rst_nosig", {31'd0, no_signal}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (meas_valid) cnt++;
    end
    chk("post_rst_valids", 32'(cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
